muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle sequencer for the long-latency integer operations of the ALU: MUL, UMULL, SMULL and DIV. It replaces the single-cycle `a * b`, 64-bit multiply and `a / b` paths with iterative 32-step engines. It sits beside the ALU in the multicycle datapath, is started by the control FSM, and stalls it via `busy`. Results are returned to the register file through a valid/ready write-back port, one word for MUL/DIV and two words (low, then high) for UMULL/SMULL.

## Interface
- `XLEN`, 32: operand and result width; only 32 is supported.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; forces IDLE.
- `start` input 1: request pulse; sampled only in IDLE.
- `op` input 2: operation: 00 MUL, 01 UMULL, 10 SMULL, 11 DIV.
- `a` input 32: operand A (multiplicand / dividend); captured on accept.
- `b` input 32: operand B (multiplier / divisor); captured on accept.
- `rd_lo` input 4: destination register for the low word or sole result; captured on accept.
- `rd_hi` input 4: destination register for the high word (UMULL/SMULL only); captured on accept.
- `busy` output 1: high from the cycle after accept until the last write-back handshake completes.
- `wb_valid` output 1: a write-back word is presented.
- `wb_ready` input 1: the register file accepts the word this cycle.
- `wb_addr` output 4: destination register of the presented word.
- `wb_data` output 32: the presented word.
- `flags` output 2: {N, Z} of the full result; valid while `wb_valid` is high.
- `div_by_zero` output 1: sticky for the current DIV; cleared on the next accept.

## Operation
- States: IDLE, CALC, WB_LO, WB_HI.
- Accept: `start` high in IDLE. Registers op, a, b, rd_lo and rd_hi, clears the 6-bit counter, and goes to CALC.
- CALC for MUL/UMULL/SMULL: shift-add over a 64-bit product register. Each cycle, if multiplier bit[0] is 1, add the multiplicand to the upper half, then shift right by 1. The result is unsigned `|a|·|b|`.
- SMULL with `MULDIV_SMULL_EN`:
  - Operands are converted to magnitudes on accept.
  - If `a[31]^b[31]` is set, the 64-bit product is two's-complement negated on the transition to WB_LO.
- CALC for DIV: restoring unsigned division over a 33-bit remainder and 32-bit quotient, one quotient bit per cycle, MSB first.
- CALC exit: after exactly 32 iterations (counter 0..31), go to WB_LO.
- DIV with `b == 0`:
  - On accept, go directly to WB_LO without entering CALC.
  - Quotient = 0xFFFFFFFF; `div_by_zero` = 1.
- WB_LO:
  - Presents: `wb_addr=rd_lo`; `wb_data` = product[31:0] for MUL/UMULL/SMULL, or the quotient for DIV.
  - On `wb_valid & wb_ready`: go to WB_HI for UMULL/SMULL; otherwise go to IDLE.
- WB_HI: presents `rd_hi` and product[63:32]; on handshake, go to IDLE.
- `flags`:
  - N = MSB of the full result (bit 63 for long multiplies, bit 31 otherwise).
  - Z = the full result is zero (64 bits for long multiplies, 32 bits otherwise).
- `start` outside IDLE is ignored, with no queuing. Operand inputs are don't-care after accept.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `wb_valid`, `div_by_zero` = 0.
  - `wb_addr`, `wb_data` = 0.
  - `flags` = 2'b00.
  - Counter and datapath registers = 0.
- Accept at edge k: `busy`=1 from cycle k+1; CALC occupies cycles k+1..k+32; `wb_valid` rises at cycle k+33.
- Divide-by-zero accept at edge k: `wb_valid` = 1 at cycle k+1.
- `wb_valid`, `wb_addr`, `wb_data` and `flags` hold stable until the handshake. Backpressure of any length adds that many cycles.
- WB_HI is presented in the cycle after the WB_LO handshake; there is no gap cycle beyond that.
- `busy` falls in the cycle after the final handshake. A new `start` is accepted in that same cycle.
- Reset mid-operation or mid-write-back: the operation is abandoned at once and no partial word is written.
- `start` high in the same cycle as the final handshake is not accepted, because the block is not yet in IDLE.

## Configuration
- `MULDIV_SMULL_EN` defined: op 10 performs signed 64-bit multiply (magnitude conversion, then sign correction).
- `MULDIV_SMULL_EN` undefined: op 10 is executed exactly as UMULL. The negation logic is not built.

## Test plan
- MUL: a=7, b=6, `wb_ready`=1. Required: `wb_valid` at accept+33, `wb_addr`=`rd_lo`, `wb_data`=0x0000002A, `flags`=00, `busy` low the next cycle.
- UMULL: a=b=0xFFFFFFFF. Required: WB_LO data 0x00000001, then WB_HI data 0xFFFFFFFE to `rd_hi`; `flags`=10 on both words.
- SMULL: a=0xFFFFFFFE (−2), b=3.
  - With the macro: lo 0xFFFFFFFA, hi 0xFFFFFFFF.
  - Without the macro: lo 0xFFFFFFFA, hi 0x00000002.
- DIV: 100/7 gives 0x0000000E at accept+33. DIV 5/0 gives `wb_valid` at accept+1, data 0xFFFFFFFF, `div_by_zero`=1. The next accepted op clears `div_by_zero`.
- Backpressure: hold `wb_ready`=0 for 5 cycles during UMULL WB_LO. Required: data stable for those cycles, no WB_HI until the handshake, and `start` pulses during this time are ignored.
- Reset asserted at CALC iteration 10. Required: all outputs return to reset values immediately, no write-back occurs, and a fresh MUL started afterwards completes correctly.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Request and write-back handshake bundle between the control FSM / register file and muldiv_sequencer.
interface muldiv_sequencer_if #(parameter int unsigned XLEN = 32);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      rd_lo;
  logic [3:0]      rd_hi;
  logic            busy;
  logic            wb_valid;
  logic            wb_ready;
  logic [3:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [1:0]      flags;
  logic            div_by_zero;

  modport master (
    output start, op, a, b, rd_lo, rd_hi, wb_ready,
    input  busy, wb_valid, wb_addr, wb_data, flags, div_by_zero
  );

  modport slave (
    input  start, op, a, b, rd_lo, rd_hi, wb_ready,
    output busy, wb_valid, wb_addr, wb_data, flags, div_by_zero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative 32-step MUL/UMULL/SMULL/DIV engine with valid/ready write-back of one or two words.
// Optional MULDIV_SMULL_EN: op 10 becomes a signed 64-bit multiply; otherwise it behaves as UMULL.
module muldiv_sequencer (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 6;
  localparam logic [1:0]  OP_UMULL = 2'b01;
  localparam logic [1:0]  OP_SMULL = 2'b10;
  localparam logic [1:0]  OP_DIV   = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, WB_LO, WB_HI} state_t;

  state_t              state_q, state_n;
  logic [CW-1:0]       cnt_q, cnt_n;
  logic [1:0]          op_q, op_n;
  logic [3:0]          rd_lo_q, rd_lo_n;
  logic [3:0]          rd_hi_q, rd_hi_n;
  logic [XLEN-1:0]     mcand_q, mcand_n;   // multiplicand, or divisor for DIV
  logic [2*XLEN-1:0]   prod_q, prod_n;     // low half holds dividend/quotient for DIV
  logic [XLEN:0]       rem_q, rem_n;
  logic [XLEN-1:0]     hi_q, hi_n;
  logic                busy_q, busy_n;
  logic                wb_valid_q, wb_valid_n;
  logic [3:0]          wb_addr_q, wb_addr_n;
  logic [XLEN-1:0]     wb_data_q, wb_data_n;
  logic [1:0]          flags_q, flags_n;
  logic                dbz_q, dbz_n;
`ifdef MULDIV_SMULL_EN
  logic                neg_q, neg_n;
`endif

  logic                long_op;
  logic [XLEN:0]       add_sum;
  logic [2*XLEN-1:0]   mul_step;
  logic [2*XLEN-1:0]   mul_res;
  logic [XLEN+1:0]     div_shift;
  logic [XLEN+1:0]     div_diff;
  logic                div_ge;
  logic [XLEN-1:0]     div_quo;
  logic [2*XLEN-1:0]   result;
  logic [XLEN-1:0]     a_mag;
  logic [XLEN-1:0]     b_mag;

  function automatic logic [1:0] flags_of(input logic [2*XLEN-1:0] r, input logic long_r);
    return long_r ? {r[2*XLEN-1], r == '0} : {r[XLEN-1], r[XLEN-1:0] == '0};
  endfunction

  assign long_op = (op_q == OP_UMULL) || (op_q == OP_SMULL);

  // One shift-add step and one restoring-division step, both from current register state
  always_comb begin : step_logic
    add_sum   = prod_q[0] ? ({1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q})
                          : {1'b0, prod_q[2*XLEN-1:XLEN]};
    mul_step  = {add_sum, prod_q[XLEN-1:1]};
`ifdef MULDIV_SMULL_EN
    mul_res   = neg_q ? (~mul_step + (2*XLEN)'(1)) : mul_step;
`else
    mul_res   = mul_step;
`endif
    div_shift = {rem_q, prod_q[XLEN-1]};
    div_ge    = div_shift >= (XLEN+2)'(mcand_q);
    div_diff  = div_shift - (XLEN+2)'(mcand_q);
    div_quo   = {prod_q[XLEN-2:0], div_ge};
    result    = (op_q == OP_DIV) ? {{XLEN{1'b0}}, div_quo} : mul_res;
  end

  // Operand magnitudes are only taken for a signed long multiply
  always_comb begin : operand_mag
`ifdef MULDIV_SMULL_EN
    a_mag = (bus.op == OP_SMULL && bus.a[XLEN-1]) ? (~bus.a + XLEN'(1)) : bus.a;
    b_mag = (bus.op == OP_SMULL && bus.b[XLEN-1]) ? (~bus.b + XLEN'(1)) : bus.b;
`else
    a_mag = bus.a;
    b_mag = bus.b;
`endif
  end

  always_comb begin : next_state
    state_n    = state_q;
    cnt_n      = cnt_q;
    op_n       = op_q;
    rd_lo_n    = rd_lo_q;
    rd_hi_n    = rd_hi_q;
    mcand_n    = mcand_q;
    prod_n     = prod_q;
    rem_n      = rem_q;
    hi_n       = hi_q;
    busy_n     = busy_q;
    wb_valid_n = wb_valid_q;
    wb_addr_n  = wb_addr_q;
    wb_data_n  = wb_data_q;
    flags_n    = flags_q;
    dbz_n      = dbz_q;
`ifdef MULDIV_SMULL_EN
    neg_n      = neg_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_n    = bus.op;
          rd_lo_n = bus.rd_lo;
          rd_hi_n = bus.rd_hi;
          cnt_n   = '0;
          rem_n   = '0;
          busy_n  = 1'b1;
          dbz_n   = 1'b0;
          hi_n    = '0;
`ifdef MULDIV_SMULL_EN
          neg_n   = (bus.op == OP_SMULL) && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
`endif
          if (bus.op == OP_DIV) begin
            mcand_n = bus.b;
            prod_n  = {{XLEN{1'b0}}, bus.a};
          end else begin
            mcand_n = a_mag;
            prod_n  = {{XLEN{1'b0}}, b_mag};
          end
          // Divide by zero skips the iterations and reports an all-ones quotient
          if (bus.op == OP_DIV && bus.b == '0) begin
            state_n    = WB_LO;
            dbz_n      = 1'b1;
            wb_valid_n = 1'b1;
            wb_addr_n  = bus.rd_lo;
            wb_data_n  = '1;
            flags_n    = 2'b10;
          end else begin
            state_n = CALC;
          end
        end
      end

      CALC: begin
        cnt_n = cnt_q + CW'(1);
        if (op_q == OP_DIV) begin
          prod_n[XLEN-1:0] = div_quo;
          rem_n            = div_ge ? (XLEN+1)'(div_diff) : (XLEN+1)'(div_shift);
        end else begin
          prod_n = mul_step;
        end
        if (cnt_q == CW'(XLEN - 1)) begin
          state_n    = WB_LO;
          wb_valid_n = 1'b1;
          wb_addr_n  = rd_lo_q;
          wb_data_n  = result[XLEN-1:0];
          hi_n       = result[2*XLEN-1:XLEN];
          flags_n    = flags_of(result, long_op);
        end
      end

      WB_LO: begin
        if (bus.wb_ready) begin
          if (long_op) begin
            state_n   = WB_HI;
            wb_addr_n = rd_hi_q;
            wb_data_n = hi_q;
          end else begin
            state_n    = IDLE;
            busy_n     = 1'b0;
            wb_valid_n = 1'b0;
            wb_addr_n  = '0;
            wb_data_n  = '0;
            flags_n    = 2'b00;
          end
        end
      end

      WB_HI: begin
        if (bus.wb_ready) begin
          state_n    = IDLE;
          busy_n     = 1'b0;
          wb_valid_n = 1'b0;
          wb_addr_n  = '0;
          wb_data_n  = '0;
          flags_n    = 2'b00;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin : state_reg
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      rd_lo_q    <= '0;
      rd_hi_q    <= '0;
      mcand_q    <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      hi_q       <= '0;
      busy_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      flags_q    <= 2'b00;
      dbz_q      <= 1'b0;
`ifdef MULDIV_SMULL_EN
      neg_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      op_q       <= op_n;
      rd_lo_q    <= rd_lo_n;
      rd_hi_q    <= rd_hi_n;
      mcand_q    <= mcand_n;
      prod_q     <= prod_n;
      rem_q      <= rem_n;
      hi_q       <= hi_n;
      busy_q     <= busy_n;
      wb_valid_q <= wb_valid_n;
      wb_addr_q  <= wb_addr_n;
      wb_data_q  <= wb_data_n;
      flags_q    <= flags_n;
      dbz_q      <= dbz_n;
`ifdef MULDIV_SMULL_EN
      neg_q      <= neg_n;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.flags       = flags_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model, per-cycle write-back scoreboard, directed vectors.
module tb_muldiv_sequencer;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [1:0]  flags;
    logic        dbz;
  } wb_t;

  wb_t expq[$];

  muldiv_sequencer_if bus();
  muldiv_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: what the operation means arithmetically
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] r, output logic [1:0] f,
                                output logic long_r, output logic dbz);
    long_r = (op == 2'd1) || (op == 2'd2);
    dbz    = 1'b0;
    case (op)
      2'd0: r = {32'd0, a * b};
      2'd1: r = {32'd0, a} * {32'd0, b};
      2'd2: begin
`ifdef MULDIV_SMULL_EN
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        r  = sa * sb;
`else
        r = {32'd0, a} * {32'd0, b};
`endif
      end
      default: begin
        if (b == 32'd0) begin
          r   = {32'd0, 32'hFFFF_FFFF};
          dbz = 1'b1;
        end else begin
          r = {32'd0, a / b};
        end
      end
    endcase
    f = long_r ? {r[63], r == 64'd0} : {r[31], r[31:0] == 32'd0};
  endfunction

  task automatic pin(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] er, input logic [1:0] ef);
    logic [63:0] r;
    logic [1:0]  f;
    logic        l, d;
    model(op, a, b, r, f, l, d);
    chk({name, "_result"}, r, er);
    chk({name, "_flags"}, 64'(f), 64'(ef));
  endtask

  // Scoreboard: every presented word must equal the head of the expected queue, every cycle
  always @(negedge clk) begin
    if (!reset && bus.wb_valid) begin
      if (expq.size() == 0) begin
        chk("spurious_wb", 64'(bus.wb_addr), 64'hDEAD);
      end else begin
        chk("wb_addr", 64'(bus.wb_addr), 64'(expq[0].addr));
        chk("wb_data", 64'(bus.wb_data), 64'(expq[0].data));
        chk("wb_flags", 64'(bus.flags), 64'(expq[0].flags));
        chk("wb_dbz", 64'(bus.div_by_zero), 64'(expq[0].dbz));
        if (bus.wb_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] rl, input logic [3:0] rh, input int bp, input bit hs_start);
    logic [63:0] r;
    logic [1:0]  f;
    logic        l, d;
    int          lat, n;
    model(op, a, b, r, f, l, d);
    expq.push_back('{addr: rl, data: r[31:0], flags: f, dbz: d});
    if (l) expq.push_back('{addr: rh, data: r[63:32], flags: f, dbz: d});

    bus.wb_ready = (bp == 0);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.rd_lo = rl; bus.rd_hi = rh;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
    bus.rd_lo = 4'($urandom); bus.rd_hi = 4'($urandom);
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    chk("dbz_after_accept", 64'(bus.div_by_zero), 64'(d));
    lat = 1;
    while (!bus.wb_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("wb_latency", 64'(lat), (op == 2'd3 && b == 32'd0) ? 64'd1 : 64'd33);

    // Backpressure: hold off the low word, poking start each cycle
    for (int i = 0; i < bp; i++) begin
      bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd3; bus.b = 32'd3;
      @(posedge clk); #1;
    end
    bus.start    = hs_start;
    bus.wb_ready = 1'b1;
    n = 0;
    while (bus.busy && n < 10) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      n++;
    end
    chk("busy_release", 64'(n), l ? 64'd2 : 64'd1);
    chk("valid_after_done", 64'(bus.wb_valid), 64'd0);
  endtask

  initial begin
    int bad;
    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
    bus.rd_lo = '0; bus.rd_hi = '0; bus.wb_ready = 1'b1;
    #12;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_addr", 64'(bus.wb_addr), 64'd0);
    chk("rst_data", 64'(bus.wb_data), 64'd0);
    chk("rst_flags", 64'(bus.flags), 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    pin("pin_mul", 2'd0, 32'd7, 32'd6, 64'h0000_0000_0000_002A, 2'b00);
    pin("pin_umull", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 2'b10);
`ifdef MULDIV_SMULL_EN
    pin("pin_smull", 2'd2, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 2'b10);
`else
    pin("pin_smull", 2'd2, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 2'b00);
`endif
    pin("pin_div", 2'd3, 32'd100, 32'd7, 64'h0000_0000_0000_000E, 2'b00);
    pin("pin_div0", 2'd3, 32'd5, 32'd0, 64'h0000_0000_FFFF_FFFF, 2'b10);

    run(2'd0, 32'd7, 32'd6, 4'd3, 4'd0, 0, 1'b0);
    run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 4'd6, 0, 1'b0);
    run(2'd2, 32'hFFFF_FFFE, 32'd3, 4'd7, 4'd8, 0, 1'b0);
    run(2'd3, 32'd100, 32'd7, 4'd9, 4'd0, 0, 1'b1);
    run(2'd3, 32'd5, 32'd0, 4'd10, 4'd0, 0, 1'b0);
    run(2'd0, 32'd3, 32'd4, 4'd11, 4'd0, 0, 1'b0);
    run(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 4'd1, 4'd2, 5, 1'b0);
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 4'd12, 4'd13, 0, 1'b0);
    run(2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 4'd14, 4'd15, 2, 1'b0);
    run(2'd3, 32'd3, 32'd10, 4'd4, 4'd0, 0, 1'b0);
    run(2'd3, 32'hFFFF_FFFF, 32'd1, 4'd6, 4'd0, 0, 1'b0);
    run(2'd3, 32'hDEAD_BEEF, 32'h0001_0003, 4'd2, 4'd0, 3, 1'b0);
    run(2'd1, 32'd0, 32'hDEAD_BEEF, 4'd8, 4'd9, 0, 1'b0);
    run(2'd0, 32'h0001_0000, 32'h0001_0000, 4'd13, 4'd0, 0, 1'b0);

    // Reset at CALC iteration 10 abandons the MUL with no write-back
    bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd9; bus.b = 32'd9; bus.rd_lo = 4'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("midop_rst_busy", 64'(bus.busy), 64'd0);
    chk("midop_rst_valid", 64'(bus.wb_valid), 64'd0);
    chk("midop_rst_data", 64'(bus.wb_data), 64'd0);
    chk("midop_rst_addr", 64'(bus.wb_addr), 64'd0);
    chk("midop_rst_flags", 64'(bus.flags), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.wb_valid || bus.busy) bad++;
    end
    chk("no_wb_after_rst", 64'(bad), 64'd0);
    run(2'd0, 32'h0000_1234, 32'h0000_5678, 4'd7, 4'd0, 0, 1'b0);

    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
